// File: rtl/alu_arb.sv
// alu_arb: two requesters share one ALU datapath. One operation is in flight
// at a time, and a round-robin pointer decides which requester wins when both
// are valid. Each operation runs IDLE (accept) -> EXEC (compute) -> RESP
// (hold the result until the owner takes it).
module alu_arb #(
  parameter int XLEN = 64,
  parameter int SHW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_x,
  input  logic [XLEN-1:0] req0_y,
  input  logic [3:0]      req0_sel,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_x,
  input  logic [XLEN-1:0] req1_y,
  input  logic [3:0]      req1_sel,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_z,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_z
);

  // Operation codes shared with the requesters.
  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_SLL  = 4'd2;
  localparam logic [3:0] SEL_SRL  = 4'd3;
  localparam logic [3:0] SEL_SRA  = 4'd4;
  localparam logic [3:0] SEL_SLT  = 4'd5;
  localparam logic [3:0] SEL_SLTU = 4'd6;
  localparam logic [3:0] SEL_XOR  = 4'd7;
  localparam logic [3:0] SEL_OR   = 4'd8;
  localparam logic [3:0] SEL_AND  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Shared ALU. Any code outside the table yields zero, so z is never X.
  function automatic logic [XLEN-1:0] alu_calc(
    input logic [3:0]      sel,
    input logic [XLEN-1:0] x,
    input logic [XLEN-1:0] y
  );
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] r;
    shamt = y[SHW-1:0];
    case (sel)
      SEL_ADD:  r = x + y;
      SEL_SUB:  r = x - y;
      SEL_SLL:  r = x << shamt;
      SEL_SRL:  r = x >> shamt;
      SEL_SRA:  r = $unsigned($signed(x) >>> shamt);
      SEL_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      SEL_SLTU: r = {{(XLEN-1){1'b0}}, (x < y)};
      SEL_XOR:  r = x ^ y;
      SEL_OR:   r = x | y;
      SEL_AND:  r = x & y;
      default:  r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  state_t          state_q, state_d;
  logic            last_q, last_d;      // requester granted most recently
  logic            owner_q, owner_d;    // requester owning the in-flight op
  logic [XLEN-1:0] x_q, x_d;
  logic [XLEN-1:0] y_q, y_d;
  logic [3:0]      sel_q, sel_d;
  logic [XLEN-1:0] z_q, z_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;

  logic            grant_s;
  logic            any_req_s;
  logic            accept_s;
  logic            rsp_take_s;

  // Round-robin pick: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Acceptance is held off while reset is asserted so nothing is granted during reset.
  assign any_req_s  = req0_valid | req1_valid;
  assign accept_s   = (state_q == ST_IDLE) && any_req_s && !rst;
  assign rsp_take_s = owner_q ? rsp1_ready : rsp0_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_take_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: request handshakes, and the next value of the registered response valids.
  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    if (accept_s) begin
      req0_ready = ~grant_s;
      req1_ready = grant_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    if (state_d == ST_RESP) begin
      rsp0_valid_d = ~owner_d;
      rsp1_valid_d = owner_d;
    end else begin
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
    end
  end

  // Datapath next state: capture operands at acceptance, compute the result in EXEC.
  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    z_d     = z_q;
    if (accept_s) begin
      last_d  = grant_s;
      owner_d = grant_s;
      x_d     = grant_s ? req1_x : req0_x;
      y_d     = grant_s ? req1_y : req0_y;
      sel_d   = grant_s ? req1_sel : req0_sel;
    end else begin
      last_d  = last_q;
      owner_d = owner_q;
    end
    if (state_q == ST_EXEC) begin
      z_d = alu_calc(sel_q, x_q, y_q);
    end else begin
      z_d = z_q;
    end
  end

  // Datapath and response registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      x_q          <= {XLEN{1'b0}};
      y_q          <= {XLEN{1'b0}};
      sel_q        <= 4'd0;
      z_q          <= {XLEN{1'b0}};
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      owner_q      <= owner_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sel_q        <= sel_d;
      z_q          <= z_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  // Both requesters see the same result register; only their valid qualifies it.
  assign rsp0_z     = z_q;
  assign rsp1_z     = z_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: scoreboard bench for alu_arb. Expected results are pushed when
// an operation is accepted and popped when the response appears.
module tb_alu_arb;

  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_SLL  = 4'd2;
  localparam logic [3:0] SEL_SRL  = 4'd3;
  localparam logic [3:0] SEL_SRA  = 4'd4;
  localparam logic [3:0] SEL_SLT  = 4'd5;
  localparam logic [3:0] SEL_SLTU = 4'd6;
  localparam logic [3:0] SEL_XOR  = 4'd7;
  localparam logic [3:0] SEL_OR   = 4'd8;
  localparam logic [3:0] SEL_AND  = 4'd9;

  typedef struct packed {
    logic        owner;
    logic [63:0] z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_x, req0_y, req1_x, req1_y;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [63:0] rsp0_z, rsp1_z;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  alu_arb #(.XLEN(64), .SHW(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z)
  );

  always #5 clk = ~clk;

  // Reference ALU, written independently of the design.
  function automatic logic [63:0] ref_alu(input logic [3:0] sel, input logic [63:0] x, input logic [63:0] y);
    logic [5:0]  s;
    logic [63:0] r;
    s = y[5:0];
    case (sel)
      SEL_ADD:  r = x + y;
      SEL_SUB:  r = x + (~y) + 64'd1;
      SEL_SLL:  r = x << s;
      SEL_SRL:  r = x >> s;
      SEL_SRA:  begin
        r = x >> s;
        if (x[63]) r = r | ~(64'hFFFF_FFFF_FFFF_FFFF >> s);
      end
      SEL_SLT:  r = (x[63] != y[63]) ? {63'd0, x[63]} : {63'd0, (x < y)};
      SEL_SLTU: r = {63'd0, (x < y)};
      SEL_XOR:  r = x ^ y;
      SEL_OR:   r = x | y;
      SEL_AND:  r = x & y;
      default:  r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic drive_req(input int n, input logic v, input logic [3:0] sel, input logic [63:0] x, input logic [63:0] y);
    if (n == 0) begin
      req0_valid = v; req0_sel = sel; req0_x = x; req0_y = y;
    end else begin
      req1_valid = v; req1_sel = sel; req1_x = x; req1_y = y;
    end
  endtask

  // One operation with rsp_ready high: accept, one EXEC cycle, response two cycles after acceptance.
  task automatic run_op(input int n, input logic [3:0] sel, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp_z, input string name);
    exp_t e;
    logic rdy, ordy, v, ov;
    logic [63:0] z;
    int w;
    @(posedge clk); #2;
    drive_req(n, 1'b1, sel, x, y);
    @(negedge clk);
    w = 0;
    rdy = (n == 0) ? req0_ready : req1_ready;
    while (rdy !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
      rdy = (n == 0) ? req0_ready : req1_ready;
    end
    ordy = (n == 0) ? req1_ready : req0_ready;
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL %s accept: ready=%b want 1", name, rdy); end
    checks++;
    if (ordy !== 1'b0) begin failures++; $display("FAIL %s other_ready: got %b want 0", name, ordy); end
    e.owner = n[0];
    e.z = exp_z;
    sb_q.push_back(e);
    @(posedge clk); #2;
    drive_req(n, 1'b0, ~sel, ~x, ~y);
    @(negedge clk);
    checks++;
    if ((rsp0_valid | rsp1_valid) !== 1'b0) begin
      failures++; $display("FAIL %s exec_valid: got %b%b want 00", name, rsp1_valid, rsp0_valid);
    end
    @(negedge clk);
    if (sb_q.size() == 0) begin
      failures++; $display("FAIL %s scoreboard: empty queue got 0 want 1 entry", name);
    end else begin
      e = sb_q.pop_front();
      v  = e.owner ? rsp1_valid : rsp0_valid;
      ov = e.owner ? rsp0_valid : rsp1_valid;
      z  = e.owner ? rsp1_z : rsp0_z;
      checks++;
      if (v !== 1'b1) begin failures++; $display("FAIL %s rsp_valid: got %b want 1", name, v); end
      checks++;
      if (ov !== 1'b0) begin failures++; $display("FAIL %s other_rsp_valid: got %b want 0", name, ov); end
      checks++;
      if (z !== e.z) begin failures++; $display("FAIL %s rsp_z: got %h want %h", name, z, e.z); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive_req(0, 1'b1, SEL_ADD, 64'd1, 64'd1);
    drive_req(1, 1'b1, SEL_ADD, 64'd2, 64'd2);
    repeat (2) @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready);
    end
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_rsp_valid: got %b%b want 00", rsp1_valid, rsp0_valid);
    end
    checks++;
    if (rsp0_z !== 64'd0) begin failures++; $display("FAIL reset_z: got %h want 0", rsp0_z); end
    @(posedge clk); #2;
    drive_req(0, 1'b0, SEL_ADD, 64'd0, 64'd0);
    drive_req(1, 1'b0, SEL_ADD, 64'd0, 64'd0);
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op(0, SEL_ADD, 64'd5, -64'sd7, 64'hFFFF_FFFF_FFFF_FFFE, "add_5_m7");
  endtask

  task automatic test_alu_ops();
    logic [3:0]  sels[11] = '{SEL_ADD, SEL_ADD, SEL_SUB, SEL_SLL, SEL_SRL, SEL_SRA,
                              SEL_SLT, SEL_SLTU, SEL_XOR, SEL_OR, SEL_AND};
    logic [63:0] xs[11] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd1,
                            64'h8000_0000_0000_0000, 64'h8000_0000_0000_0010, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'd1, 64'hF0F0, 64'hF0F0, 64'hF0F0};
    logic [63:0] ys[11] = '{64'd1, 64'd2, 64'd5, 64'h47, 64'd4, 64'h41, 64'd1,
                            64'hFFFF_FFFF_FFFF_FFFF, 64'hFF00, 64'hFF00, 64'hFF00};
    for (int i = 0; i < 11; i++) begin
      run_op(i % 2, sels[i], xs[i], ys[i], ref_alu(sels[i], xs[i], ys[i]), $sformatf("op%0d_sel%0d", i, sels[i]));
    end
    run_op(1, SEL_SRA, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, "sra_spec");
    run_op(0, SEL_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, "sltu_spec");
  endtask

  task automatic test_round_robin();
    int acc_cyc[$];
    int acc_id[$];
    exp_t e;
    logic [63:0] z;
    @(posedge clk); #2;
    rst = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive_req(0, 1'b1, SEL_ADD, 64'd1, 64'd2);
    drive_req(1, 1'b1, SEL_SUB, 64'd10, 64'd3);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      failures++; $display("FAIL rr_reset_ready: got %b%b want 00", req1_ready, req0_ready);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) begin
        checks++; failures++;
        $display("FAIL rr_double_grant: got 11 want one-hot at cycle %0d", c);
      end
      if (req0_ready || req1_ready) begin
        acc_cyc.push_back(c);
        acc_id.push_back(req1_ready ? 1 : 0);
        e.owner = req1_ready;
        e.z = req1_ready ? 64'd7 : 64'd3;
        sb_q.push_back(e);
      end
      if (rsp0_valid || rsp1_valid) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rr_scoreboard: unexpected response got valid want none");
        end else begin
          e = sb_q.pop_front();
          z = e.owner ? rsp1_z : rsp0_z;
          checks++;
          if ({rsp1_valid, rsp0_valid} !== (e.owner ? 2'b10 : 2'b01)) begin
            failures++; $display("FAIL rr_rsp_owner: got %b%b want owner %0d", rsp1_valid, rsp0_valid, e.owner);
          end
          checks++;
          if (z !== e.z) begin failures++; $display("FAIL rr_rsp_z: got %h want %h", z, e.z); end
        end
      end
    end
    @(posedge clk); #2;
    drive_req(0, 1'b0, SEL_ADD, 64'd0, 64'd0);
    drive_req(1, 1'b0, SEL_ADD, 64'd0, 64'd0);
    checks++;
    if (acc_id.size() != 4) begin
      failures++; $display("FAIL rr_grant_count: got %0d want 4", acc_id.size());
    end
    for (int k = 0; k < acc_id.size(); k++) begin
      checks++;
      if (acc_id[k] != k % 2) begin failures++; $display("FAIL rr_grant_%0d: got %0d want %0d", k, acc_id[k], k % 2); end
      if (k > 0) begin
        checks++;
        if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
          failures++; $display("FAIL rr_interval_%0d: got %0d want 3", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL rr_leftover: got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int w;
    @(posedge clk); #2;
    rsp0_ready = 1'b0;
    drive_req(0, 1'b1, SEL_ADD, 64'd100, 64'd23);
    drive_req(1, 1'b1, SEL_SUB, 64'd999, 64'd1);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_accept: got %b%b want 01", req1_ready, req0_ready);
    end
    e.owner = 1'b0; e.z = 64'd123;
    sb_q.push_back(e);
    @(posedge clk); #2;
    drive_req(0, 1'b0, SEL_ADD, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    e = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_z !== e.z || rsp1_valid !== 1'b0) begin
        failures++; $display("FAIL bp_hold_%0d: got v=%b z=%h want v=1 z=%h", i, rsp0_valid, rsp0_z, e.z);
      end
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        failures++; $display("FAIL bp_ready_%0d: got %b%b want 00", i, req1_ready, req0_ready);
      end
      @(posedge clk); #2;
      req1_x = 64'd1000 + 64'(i);
      @(negedge clk);
    end
    @(posedge clk); #2;
    rsp0_ready = 1'b1;
    drive_req(1, 1'b1, SEL_SUB, 64'd50, 64'd8);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release: got v=%b rdy1=%b want v=0 rdy1=1", rsp0_valid, req1_ready);
    end
    e.owner = 1'b1; e.z = 64'd42;
    sb_q.push_back(e);
    @(posedge clk); #2;
    drive_req(1, 1'b0, SEL_ADD, 64'd0, 64'd0);
    w = 0;
    @(negedge clk);
    while (rsp1_valid !== 1'b1 && w < 6) begin @(negedge clk); w++; end
    e = sb_q.pop_front();
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_z !== e.z) begin
      failures++; $display("FAIL bp_after: got v=%b z=%h want v=1 z=%h", rsp1_valid, rsp1_z, e.z);
    end
  endtask

  task automatic test_reset_in_exec();
    @(posedge clk); #2;
    drive_req(0, 1'b1, SEL_AND, 64'hFF, 64'h0F);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin failures++; $display("FAIL rst_exec_accept: got %b want 1", req0_ready); end
    @(posedge clk); #2;
    drive_req(0, 1'b0, SEL_ADD, 64'd0, 64'd0);
    drive_req(1, 1'b1, SEL_ADD, 64'd4, 64'd4);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0000 || rsp0_z !== 64'd0) begin
      failures++; $display("FAIL rst_exec_outputs: got rdy=%b%b v=%b%b z=%h want 0", req1_ready, req0_ready,
                           rsp1_valid, rsp0_valid, rsp0_z);
    end
    @(posedge clk); #2;
    drive_req(1, 1'b0, SEL_ADD, 64'd0, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp1_valid, rsp0_valid} !== 2'b00 || rsp0_z !== 64'd0) begin
        failures++; $display("FAIL rst_exec_dropped_%0d: got v=%b%b z=%h want 00 z=0", i, rsp1_valid, rsp0_valid, rsp0_z);
      end
    end
  endtask

  task automatic test_undefined_sel();
    run_op(0, 4'hF, 64'h1234, 64'h5678, 64'd0, "undef_sel");
    run_op(1, SEL_OR, 64'h1234, 64'h5678, 64'h567C, "after_undef");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_round_robin();
    test_backpressure();
    test_reset_in_exec();
    test_undefined_sel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
